// File: rtl/twf0_1_sched.sv
`default_nettype none
// ============================================================================
//  Module   : twf0_1_sched
//  Purpose  : Stage-0/1 twiddle-factor fetch sequencer for the 512-point FFT.
//             Steps the group index into a 1-cycle registered ROM bank and
//             presents each group to the multiplier over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module twf0_1_sched #(
  parameter int NUM_GRP = 32,
  parameter int GRP_W   = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  output logic [GRP_W-1:0] grp_idx,
  output logic             tw_valid,
  input  logic             tw_ready,
  output logic [GRP_W-1:0] tw_grp,
  output logic             tw_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [GRP_W-1:0] c_LAST = GRP_W'(NUM_GRP - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [GRP_W-1:0] r_cnt;
  logic [GRP_W-1:0] w_cnt_nxt;
  logic             w_fire;
  logic             w_last;

  assign w_fire = (r_state == S_RUN) && tw_ready;
  assign w_last = (r_cnt == c_LAST);

  // Look one group ahead on an accepted beat so the ROM register lands on the
  // next cnt value; on a stall it re-reads cnt, keeping the ROM output stable.
  assign grp_idx  = (w_fire && !w_last) ? r_cnt + GRP_W'(1) : r_cnt;
  assign tw_grp   = r_cnt;
  assign tw_valid = (r_state == S_RUN);
  assign tw_last  = (r_state == S_RUN) && w_last;
  assign busy     = (r_state == S_PRIME) || (r_state == S_RUN);
  assign done     = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (start) w_state_nxt = S_PRIME;
      end
      S_PRIME: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_fire) begin
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt = r_cnt + GRP_W'(1);
          end
        end
      end
      S_DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_twf0_1_sched.sv
`default_nettype none
// Scoreboard bench for twf0_1_sched: expected beats/done pulses are queued at
// stimulus time and a negedge monitor pops them against DUT handshakes.
`timescale 1ns/1ps
module tb_twf0_1_sched;
  localparam int NG = 32;
  localparam int GW = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          tw_ready = 1'b0;
  logic [GW-1:0] grp_idx, tw_grp;
  logic          tw_valid, tw_last, busy, done;

  logic          start2 = 1'b0;
  logic          ready2 = 1'b0;
  logic [0:0]    grp_idx2, tw_grp2;
  logic          valid2, last2, busy2, done2;

  always #5 clk = ~clk;

  twf0_1_sched #(.NUM_GRP(NG), .GRP_W(GW)) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .grp_idx(grp_idx), .tw_valid(tw_valid), .tw_ready(tw_ready),
    .tw_grp(tw_grp), .tw_last(tw_last), .busy(busy), .done(done)
  );

  twf0_1_sched #(.NUM_GRP(2), .GRP_W(1)) u_dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .abort(1'b0),
    .grp_idx(grp_idx2), .tw_valid(valid2), .tw_ready(ready2),
    .tw_grp(tw_grp2), .tw_last(last2), .busy(busy2), .done(done2)
  );

  // Model of the registered ROM bank: output holds the group addressed last edge.
  logic [GW-1:0] rom_q;
  always @(posedge clk) rom_q <= grp_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];
  int done_pend = 0;
  int start_cyc = -1;
  int mode = 0;
  int stalls = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Downstream ready policy
  always @(posedge clk) begin
    #1;
    case (mode)
      0: tw_ready = 1'b1;
      1: tw_ready = 1'($urandom_range(0, 1));
      2: begin
        if (tw_valid && tw_grp == 5 && stalls < 3) begin
          tw_ready = 1'b0;
          stalls++;
        end else begin
          tw_ready = 1'b1;
        end
      end
      default: tw_ready = !(tw_valid && tw_grp == 17);
    endcase
  end

  // Monitor
  logic          pv = 1'b0, pr = 1'b0, pl = 1'b0, pa = 1'b0;
  logic [GW-1:0] pg = '0;
  int            last_fire_cyc = -10;
  always @(negedge clk) begin
    if (!rstn) begin
      pv = 1'b0; pr = 1'b0; pl = 1'b0; pa = 1'b0;
    end else begin
      if (tw_valid) begin
        check("rom_match", int'(rom_q), int'(tw_grp));
        if (!pv && start_cyc >= 0) begin
          check("first_valid_latency", cyc - start_cyc, 2);
          start_cyc = -1;
        end
        if (!tw_ready) check("stall_grp_idx", int'(grp_idx), int'(tw_grp));
      end
      if (pv && !pr && !pa) begin
        check("stall_valid_held", int'(tw_valid), 1);
        check("stall_grp_held", int'(tw_grp), int'(pg));
      end
      if (pv && pr && !pl && !pa) check("no_bubble", int'(tw_valid), 1);
      if (tw_valid && tw_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          int e;
          e = exp_q.pop_front();
          check("beat_grp", int'(tw_grp), e / 2);
          check("beat_last", int'(tw_last), e % 2);
        end
        if (tw_last) last_fire_cyc = cyc;
      end
      if (done) begin
        if (done_pend == 0) begin
          fail_now("spurious_done");
        end else begin
          done_pend--;
          check("done_after_last", cyc - last_fire_cyc, 1);
        end
      end
      pv = tw_valid; pr = tw_ready; pl = tw_last; pa = abort; pg = tw_grp;
    end
  end

  task automatic launch();
    @(posedge clk); #2;
    for (int i = 0; i < NG; i++) exp_q.push_back(i * 2 + ((i == NG - 1) ? 1 : 0));
    done_pend++;
    start_cyc = cyc;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_pend != 0 || busy || done) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= budget) begin
      fail_now({name, "_timeout"});
      exp_q.delete();
      done_pend = 0;
    end
    check({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic wait_grp(input int g, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(tw_valid && tw_grp == GW'(g)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now({name, "_wait_timeout"});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #23;
    check("rst_valid", int'(tw_valid), 0);
    check("rst_grp", int'(tw_grp), 0);
    check("rst_idx", int'(grp_idx), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_last", int'(tw_last), 0);
    @(posedge clk); #2;
    rstn = 1'b1;
    repeat (3) @(posedge clk);

    // Two-group variant, directed cycle by cycle
    ready2 = 1'b1;
    @(posedge clk); #2; start2 = 1'b1;
    @(posedge clk); #2; start2 = 1'b0;
    check("n2_prime_busy", int'(busy2), 1);
    check("n2_prime_valid", int'(valid2), 0);
    check("n2_prime_idx", int'(grp_idx2), 0);
    @(posedge clk); #2;
    check("n2_beat0_valid", int'(valid2), 1);
    check("n2_beat0_grp", int'(tw_grp2), 0);
    check("n2_beat0_last", int'(last2), 0);
    check("n2_beat0_idx", int'(grp_idx2), 1);
    @(posedge clk); #2;
    check("n2_beat1_valid", int'(valid2), 1);
    check("n2_beat1_grp", int'(tw_grp2), 1);
    check("n2_beat1_last", int'(last2), 1);
    @(posedge clk); #2;
    check("n2_done", int'(done2), 1);
    check("n2_done_valid", int'(valid2), 0);
    @(posedge clk); #2;
    check("n2_idle_done", int'(done2), 0);
    check("n2_idle_busy", int'(busy2), 0);

    // Full pass, ready held high
    mode = 0;
    launch();
    check("prime_busy", int'(busy), 1);
    check("prime_valid", int'(tw_valid), 0);
    wait_idle(100, "full_pass");
    check("full_pass_busy_after", int'(busy), 0);

    // Three-cycle stall on group 5
    mode = 2; stalls = 0;
    launch();
    wait_idle(100, "stall_pass");
    check("stall_count", stalls, 3);

    // Random ready
    mode = 1;
    launch();
    wait_idle(500, "random_pass");

    // Abort while stalled on group 17
    mode = 3;
    launch();
    wait_grp(17, "abort");
    @(posedge clk); #2;
    abort = 1'b1;
    exp_q.delete(); done_pend = 0; start_cyc = -1;
    @(posedge clk); #2;
    abort = 1'b0;
    check("abort_valid", int'(tw_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_grp", int'(tw_grp), 0);
    check("abort_done", int'(done), 0);
    repeat (5) @(posedge clk);
    mode = 0;
    launch();
    wait_idle(100, "after_abort");

    // Starts during RUN and DONE are ignored
    mode = 0;
    launch();
    repeat (4) @(posedge clk);
    #2; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    wait_grp(NG - 1, "late_start");
    @(posedge clk); #2;
    check("done_cycle", int'(done), 1);
    start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    check("ignored_start_busy", int'(busy), 0);
    wait_idle(10, "ignored_start");

    // Asynchronous reset at group 9
    mode = 0;
    launch();
    wait_grp(9, "reset");
    #2; rstn = 1'b0;
    exp_q.delete(); done_pend = 0; start_cyc = -1;
    #1;
    check("arst_valid", int'(tw_valid), 0);
    check("arst_grp", int'(tw_grp), 0);
    check("arst_idx", int'(grp_idx), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_last", int'(tw_last), 0);
    check("arst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #2; rstn = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("post_rst_idle_valid", int'(tw_valid), 0);
    check("post_rst_idle_busy", int'(busy), 0);
    launch();
    wait_idle(100, "post_reset_pass");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
